pc_fetch: RTL

//  Program counter and instruction-fetch stage of the Hack CPU. Holds the 16-bit PC, advances it with
//  inc16 (a+1 mod 2^16), issues reads to the synchronous instruction ROM and hands fetched words to

---
 rtl/pc_fetch_if.sv | 23 ++
 rtl/pc_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: jump redirect, ROM read port and decode handshake.
// The fetch stage is the master; the ROM/execute/decode side is the slave.
interface pc_fetch_if;
    logic        jump_valid;
    logic [15:0] jump_addr;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;

    modport master (
        input  jump_valid, jump_addr, rom_data, instr_ready,
        output rom_en, rom_addr, instr_valid, instr_data, instr_pc
    );

    modport slave (
        output jump_valid, jump_addr, rom_data, instr_ready,
        input  rom_en, rom_addr, instr_valid, instr_data, instr_pc
    );
endinterface

// File: rtl/pc_fetch.sv
// Hack CPU program counter and instruction fetch stage.
// One ROM read in flight, 2-entry output queue, credit-based issue.
module pc_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic clk,
    input  logic rst_n,
    pc_fetch_if.master bus
);

    typedef enum logic {
        S_RESET = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
    } fetch_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_q;
    logic        inflight_q;
    logic [15:0] inflight_pc_q;
    logic        drop_q;
    fetch_t      fifo_q [2];
    fetch_t      fifo_d [2];
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [1:0]  count_pop;

    logic        run;
    logic        jump;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  credit;

    assign run    = (state_q == S_RUN);
    assign jump   = run & bus.jump_valid;
    assign pop    = (count_q != 2'd0) & bus.instr_ready;
    // A return landing in a jump cycle belongs to the old stream.
    assign push   = inflight_q & ~drop_q & ~jump;
    // Occupancy after this cycle's pop; reserves a slot for the read in flight.
    assign credit = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

    // FSM state register: leaves RESET on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // FSM next state: RUN is sticky until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
        endcase
    end

    // FSM output: ROM strobe only while running, no jump, and queue credit left
    always_comb begin
        issue = 1'b0;
        case (state_q)
            S_RESET: issue = 1'b0;
            S_RUN:   issue = ~bus.jump_valid & (credit < 3'd2);
        endcase
    end

    assign bus.rom_en   = issue;
    assign bus.rom_addr = pc_q;

    // PC and in-flight read tracking; a jump redirects and kills the old read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0000;
            drop_q        <= 1'b0;
        end else if (jump) begin
            pc_q       <= bus.jump_addr;
            inflight_q <= 1'b0;
            drop_q     <= 1'b1;
        end else if (issue) begin
            pc_q          <= pc_q + 16'd1;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
            drop_q        <= 1'b0;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    // Queue next state: pop shifts head, push fills first free slot, jump empties
    always_comb begin
        fifo_d    = fifo_q;
        count_pop = count_q - {1'b0, pop};
        count_d   = count_pop;
        if (pop) fifo_d[0] = fifo_q[1];
        if (push) begin
            fifo_d[count_pop[0]] = '{data: bus.rom_data, pc: inflight_pc_q};
            count_d = count_pop + 2'd1;
        end
        if (jump) count_d = 2'd0;
    end

    // Queue registers; head is registered so ROM data never reaches decode directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            count_q   <= 2'd0;
        end else begin
            fifo_q    <= fifo_d;
            count_q   <= count_d;
        end
    end

    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.instr_data  = fifo_q[0].data;
    assign bus.instr_pc    = fifo_q[0].pc;

    a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, count_q} + {2'b0, inflight_q}) <= 3'd2);

endmodule
